// File: rtl/pipe_hazard_ctrl_pkg.sv
// pipe_hazard_ctrl_pkg: shared constants and types for the pipeline sequencer
package pipe_hazard_ctrl_pkg;
  localparam logic [2:0] NO_EXP = 3'd0;
  localparam logic [2:0] EXP_INT = 3'd7;
  localparam logic ENABLE = 1'b1;
  localparam logic DISABLE = 1'b0;
  localparam logic WE_ENABLE_ = 1'b0;
  typedef enum logic {RUN, PEND} state_e;
  typedef enum logic [1:0] {EVT_NONE, EVT_EXC, EVT_ERET, EVT_INT} evt_e;
endpackage

// File: rtl/pipe_hazard_ctrl_hazard_detect.sv
// pipe_hazard_ctrl_hazard_detect: load-use compare between the ID sources and the EX load destination
module pipe_hazard_ctrl_hazard_detect
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int REG_W = 5
) (
  input  logic             id_en,
  input  logic [REG_W-1:0] id_ra_addr,
  input  logic [REG_W-1:0] id_rb_addr,
  input  logic             id_ra_use,
  input  logic             id_rb_use,
  input  logic             ex_en,
  input  logic [REG_W-1:0] ex_dst_addr,
  input  logic             ex_gpr_we_,
  input  logic             ex_is_load,
  output logic             load_use
);
  // r0 is hardwired zero, so a load targeting it never creates a dependency
  always_comb begin
    load_use = id_en & ex_en & ex_is_load & (ex_gpr_we_ == WE_ENABLE_) & (ex_dst_addr != '0) &
               ((id_ra_use & (id_ra_addr == ex_dst_addr)) | (id_rb_use & (id_rb_addr == ex_dst_addr)));
  end
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: per-stage stall/flush, load-use bubbles, PC redirect and exception context
module pipe_hazard_ctrl
  import pipe_hazard_ctrl_pkg::*;
#(
  parameter int              ADDR_W     = 30,
  parameter int              REG_W      = 5,
  parameter int              EXP_W      = 3,
  parameter logic [ADDR_W-1:0] EXC_VECTOR = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_busy,
  input  logic              mem_busy,
  input  logic              id_en,
  input  logic [REG_W-1:0]  id_ra_addr,
  input  logic [REG_W-1:0]  id_rb_addr,
  input  logic              id_ra_use,
  input  logic              id_rb_use,
  input  logic              ex_en,
  input  logic [REG_W-1:0]  ex_dst_addr,
  input  logic              ex_gpr_we_,
  input  logic              ex_is_load,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_addr,
  input  logic              mem_en,
  input  logic [ADDR_W-1:0] mem_pc,
  input  logic [EXP_W-1:0]  mem_exp_code,
  input  logic              mem_eret,
  input  logic              int_req,
  output logic              if_stall,
  output logic              id_stall,
  output logic              ex_stall,
  output logic              mem_stall,
  output logic              if_flush,
  output logic              id_flush,
  output logic              ex_flush,
  output logic              mem_flush,
  output logic              pc_load,
  output logic [ADDR_W-1:0] new_pc,
  output logic [ADDR_W-1:0] epc,
  output logic [EXP_W-1:0]  exp_cause,
  output logic              int_en
);
  state_e            state_q, state_d;
  evt_e              pend_kind_q, pend_kind_d, evt, take_kind;
  logic [ADDR_W-1:0] pend_pc_q, pend_pc_d, epc_q, epc_d, take_pc;
  logic [EXP_W-1:0]  pend_code_q, pend_code_d, exp_cause_q, exp_cause_d, evt_code, take_code;
  logic              int_en_q, int_en_d;
  logic              load_use, gs, take, lu_go, br_go;

  pipe_hazard_ctrl_hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
    .id_en      (id_en),
    .id_ra_addr (id_ra_addr),
    .id_rb_addr (id_rb_addr),
    .id_ra_use  (id_ra_use),
    .id_rb_use  (id_rb_use),
    .ex_en      (ex_en),
    .ex_dst_addr(ex_dst_addr),
    .ex_gpr_we_ (ex_gpr_we_),
    .ex_is_load (ex_is_load),
    .load_use   (load_use)
  );

  // Prioritise MEM events and pick either the live event or the one latched during a bus wait
  always_comb begin
    gs = if_busy | mem_busy;
    evt = (mem_en & (mem_exp_code != EXP_W'(NO_EXP))) ? EVT_EXC :
          (mem_en & mem_eret) ? EVT_ERET :
          (int_req & int_en_q & mem_en) ? EVT_INT : EVT_NONE;
    evt_code = (evt == EVT_EXC) ? mem_exp_code : EXP_W'(EXP_INT);
    take_kind = (state_q == PEND) ? pend_kind_q : evt;
    take_pc = (state_q == PEND) ? pend_pc_q : mem_pc;
    take_code = (state_q == PEND) ? pend_code_q : evt_code;
    take = ~reset & ~gs & (take_kind != EVT_NONE);
    lu_go = ~reset & ~gs & ~take & load_use;
    br_go = ~reset & ~gs & ~take & ~load_use & br_taken;
  end

  // Bus wait freezes everything; events beat load-use, which beats branches
  always_comb begin
    if_stall = (~reset & gs) | lu_go;
    id_stall = ~reset & gs;
    ex_stall = ~reset & gs;
    mem_stall = ~reset & gs;
    if_flush = take | br_go;
    id_flush = take | lu_go;
    ex_flush = take;
    mem_flush = take;
    pc_load = take | br_go;
    new_pc = take ? ((take_kind == EVT_ERET) ? epc_q : EXC_VECTOR) : br_go ? br_addr : '0;
  end

  // Defer events across bus waits and update the exception context when one is taken
  always_comb begin
    state_d = state_q;
    pend_kind_d = pend_kind_q;
    pend_pc_d = pend_pc_q;
    pend_code_d = pend_code_q;
    epc_d = epc_q;
    exp_cause_d = exp_cause_q;
    int_en_d = int_en_q;
    if (state_q == RUN && gs && evt != EVT_NONE) begin
      state_d = PEND;
      pend_kind_d = evt;
      pend_pc_d = mem_pc;
      pend_code_d = evt_code;
    end
    if (state_q == PEND && !gs) begin
      state_d = RUN;
      pend_kind_d = EVT_NONE;
    end
    if (take && take_kind != EVT_ERET) begin
      epc_d = take_pc;
      exp_cause_d = take_code;
      int_en_d = DISABLE;
    end
    if (take && take_kind == EVT_ERET) int_en_d = ENABLE;
  end

  // State and context registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= RUN;
      pend_kind_q <= EVT_NONE;
      pend_pc_q <= '0;
      pend_code_q <= '0;
      epc_q <= '0;
      exp_cause_q <= '0;
      int_en_q <= ENABLE;
    end else begin
      state_q <= state_d;
      pend_kind_q <= pend_kind_d;
      pend_pc_q <= pend_pc_d;
      pend_code_q <= pend_code_d;
      epc_q <= epc_d;
      exp_cause_q <= exp_cause_d;
      int_en_q <= int_en_d;
    end
  end

  assign epc = epc_q;
  assign exp_cause = exp_cause_q;
  assign int_en = int_en_q;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed and random checks against a behavioural sequencer model
module tb_pipe_hazard_ctrl;
  logic        clk = 0, reset = 1;
  logic        if_busy, mem_busy, id_en, id_ra_use, id_rb_use, ex_en, ex_gpr_we_, ex_is_load;
  logic [4:0]  id_ra_addr, id_rb_addr, ex_dst_addr;
  logic        br_taken, mem_en, mem_eret, int_req;
  logic [29:0] br_addr, mem_pc;
  logic [2:0]  mem_exp_code;
  logic        if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush, pc_load;
  logic [29:0] new_pc, epc;
  logic [2:0]  exp_cause;
  logic        int_en;
  int          n_checks = 0, n_errors = 0;
  int          m_pend;
  logic [29:0] m_ppc, m_epc;
  logic [2:0]  m_pcode, m_cause;
  logic        m_ie;

  localparam logic [29:0] EXC_VEC = 30'h0;

  pipe_hazard_ctrl dut (
    .clk(clk), .reset(reset), .if_busy(if_busy), .mem_busy(mem_busy),
    .id_en(id_en), .id_ra_addr(id_ra_addr), .id_rb_addr(id_rb_addr),
    .id_ra_use(id_ra_use), .id_rb_use(id_rb_use), .ex_en(ex_en),
    .ex_dst_addr(ex_dst_addr), .ex_gpr_we_(ex_gpr_we_), .ex_is_load(ex_is_load),
    .br_taken(br_taken), .br_addr(br_addr), .mem_en(mem_en), .mem_pc(mem_pc),
    .mem_exp_code(mem_exp_code), .mem_eret(mem_eret), .int_req(int_req),
    .if_stall(if_stall), .id_stall(id_stall), .ex_stall(ex_stall), .mem_stall(mem_stall),
    .if_flush(if_flush), .id_flush(id_flush), .ex_flush(ex_flush), .mem_flush(mem_flush),
    .pc_load(pc_load), .new_pc(new_pc), .epc(epc), .exp_cause(exp_cause), .int_en(int_en)
  );

  always #5 clk = ~clk;

  task automatic check(string tag, logic [63:0] got, logic [63:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
    end
  endtask

  task automatic idle();
    {if_busy, mem_busy, id_en, id_ra_use, id_rb_use, ex_en, ex_is_load} = '0;
    ex_gpr_we_ = 1;
    {id_ra_addr, id_rb_addr, ex_dst_addr} = '0;
    {br_taken, mem_en, mem_eret, int_req} = '0;
    br_addr = '0; mem_pc = '0; mem_exp_code = '0;
  endtask

  // 0 none, 1 exception, 2 eret, 3 interrupt
  function automatic int live_event();
    if (mem_en && mem_exp_code != 0) return 1;
    if (mem_en && mem_eret) return 2;
    if (int_req && m_ie && mem_en) return 3;
    return 0;
  endfunction

  task automatic step();
    logic [8:0]  w_ctl;
    logic [29:0] w_pc;
    int          ev;
    bit          gs, lu;
    gs = if_busy | mem_busy;
    lu = id_en && ex_en && ex_is_load && !ex_gpr_we_ && ex_dst_addr != 0 &&
         ((id_ra_use && id_ra_addr == ex_dst_addr) || (id_rb_use && id_rb_addr == ex_dst_addr));
    ev = (m_pend != 0) ? m_pend : live_event();
    w_ctl = '0;
    w_pc = '0;
    if (reset) ;
    else if (gs) w_ctl = 9'b1111_0000_0;
    else if (ev != 0) begin
      w_ctl = 9'b0000_1111_1;
      w_pc = (ev == 2) ? m_epc : EXC_VEC;
    end else if (lu) w_ctl = 9'b1000_0100_0;
    else if (br_taken) begin
      w_ctl = 9'b0000_1000_1;
      w_pc = br_addr;
    end
    @(negedge clk);
    check("ctl", {if_stall, id_stall, ex_stall, mem_stall, if_flush, id_flush, ex_flush, mem_flush, pc_load}, w_ctl);
    check("new_pc", new_pc, w_pc);
    check("epc", epc, m_epc);
    check("exp_cause", exp_cause, m_cause);
    check("int_en", int_en, m_ie);
    @(posedge clk);
    if (reset) begin
      m_pend = 0; m_epc = 0; m_cause = 0; m_ie = 1;
    end else if (gs) begin
      if (m_pend == 0 && live_event() != 0) begin
        m_pend = live_event();
        m_ppc = mem_pc;
        m_pcode = (m_pend == 1) ? mem_exp_code : 3'd7;
      end
    end else begin
      if (ev == 2) m_ie = 1;
      else if (ev != 0) begin
        m_epc = (m_pend != 0) ? m_ppc : mem_pc;
        m_cause = (m_pend != 0) ? m_pcode : (ev == 1 ? mem_exp_code : 3'd7);
        m_ie = 0;
      end
      m_pend = 0;
    end
    #1;
  endtask

  initial begin
    idle();
    m_pend = 0; m_epc = 0; m_cause = 0; m_ie = 1; m_ppc = 0; m_pcode = 0;
    mem_busy = 1; mem_en = 1; mem_exp_code = 3'd5;
    step();
    idle();
    step();
    reset = 0;
    step();
    // load-use, then the same with r0 as destination
    ex_en = 1; ex_is_load = 1; ex_gpr_we_ = 0; ex_dst_addr = 3;
    id_en = 1; id_ra_addr = 3; id_ra_use = 1; id_rb_addr = 2; id_rb_use = 1;
    step();
    idle();
    step();
    ex_en = 1; ex_is_load = 1; ex_gpr_we_ = 0; ex_dst_addr = 0;
    id_en = 1; id_ra_addr = 0; id_ra_use = 1;
    step();
    check("lu_r0_no_stall", if_stall, 0);
    idle();
    // branch
    br_taken = 1; br_addr = 30'h40;
    step();
    idle();
    step();
    // exception then ERET
    mem_en = 1; mem_pc = 30'h100; mem_exp_code = 3'd2;
    step();
    idle();
    step();
    check("exc_epc", epc, 30'h100);
    check("exc_cause", exp_cause, 2);
    check("exc_int_en", int_en, 0);
    mem_en = 1; mem_eret = 1;
    step();
    idle();
    step();
    check("eret_int_en", int_en, 1);
    // deferred exception over a 3-cycle data-bus wait
    mem_en = 1; mem_pc = 30'h100; mem_exp_code = 3'd2; mem_busy = 1;
    repeat (3) step();
    mem_busy = 0;
    step();
    idle();
    step();
    mem_en = 1; mem_eret = 1;
    step();
    idle();
    // interrupt masked behind an exception until ERET
    int_req = 1; mem_en = 1; mem_pc = 30'h200; mem_exp_code = 3'd1;
    step();
    mem_exp_code = 0; mem_pc = 30'h204;
    step();
    check("int_cause_exc", exp_cause, 1);
    check("int_masked", int_en, 0);
    mem_eret = 1;
    step();
    mem_eret = 0; mem_pc = 30'h208;
    step();
    step();
    check("int_cause", exp_cause, 7);
    check("int_epc", epc, 30'h208);
    idle();
    mem_en = 1; mem_eret = 1;
    step();
    idle();
    // reset while an event is pending
    mem_busy = 1; mem_en = 1; mem_pc = 30'h300; mem_exp_code = 3'd4;
    step();
    reset = 1;
    step();
    reset = 0; idle();
    step();
    check("pend_discarded", mem_flush, 0);
    // random traffic
    for (int i = 0; i < 600; i++) begin
      reset = ($urandom_range(0, 59) == 0);
      if_busy = ($urandom_range(0, 5) == 0);
      mem_busy = ($urandom_range(0, 5) == 0);
      id_en = $urandom_range(0, 1);
      id_ra_addr = 5'($urandom_range(0, 3));
      id_rb_addr = 5'($urandom_range(0, 3));
      id_ra_use = $urandom_range(0, 1);
      id_rb_use = $urandom_range(0, 1);
      ex_en = $urandom_range(0, 1);
      ex_dst_addr = 5'($urandom_range(0, 3));
      ex_gpr_we_ = $urandom_range(0, 1);
      ex_is_load = $urandom_range(0, 1);
      br_taken = $urandom_range(0, 1);
      br_addr = 30'($urandom);
      mem_en = $urandom_range(0, 1);
      mem_pc = 30'($urandom);
      mem_exp_code = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(1, 7)) : 3'd0;
      mem_eret = ($urandom_range(0, 5) == 0);
      int_req = ($urandom_range(0, 3) == 0);
      step();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
